// File: rtl/spi_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_frame_rx
//
// SPI mode-0 frame receiver for the PWM configuration path. The raw SPI pins
// are synchronised into the clk domain and 16-bit frames are deserialised,
// MSB first. Each completed frame is checked when nCS rises. Accepted writes
// are offered to the register bank as a single-entry valid/ready stream.
// Read frames, malformed frames and overruns never reach the register bank.
//
// Frame layout: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
//
// Parameters
//   SYNC_STAGES  synchroniser depth per SPI pin (>= 2)
//   ADDR_MAX     highest legal register address; higher addresses are dropped
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   sclk_in    raw SPI clock
//   copi_in    raw SPI data, controller to peripheral
//   ncs_in     raw SPI chip select, active low
//   wr_valid   accepted write pending
//   wr_ready   consumer takes the write on an edge where wr_valid & wr_ready
//   wr_addr    register address of the pending write
//   wr_data    register data of the pending write
//   busy       frame in progress
//   frame_err  one-cycle pulse on a bad bit count or an overrun
// -----------------------------------------------------------------------------
module spi_frame_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_MAX    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk_in,
   input  logic       copi_in,
   input  logic       ncs_in,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       frame_err
);

   // Edge detection stays disabled until the synchronisers and history flops
   // hold real pin values. Otherwise the nCS reset value of 1 would show up as
   // a false falling edge when rst is released while ncs_in is already low.
   localparam int                FILL_MAX  = SYNC_STAGES + 1;
   localparam int                FILL_W    = $clog2(FILL_MAX + 1);
   localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(FILL_MAX);
   localparam logic [6:0]        ADDR_LIM  = 7'(ADDR_MAX);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   // ---------------------------------------------------------------------------
   // Synchronisers and edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] copi_sync;
   logic [SYNC_STAGES-1:0] ncs_sync;
   logic                   sclk_hist;
   logic                   copi_hist;
   logic                   ncs_hist;
   logic [FILL_W-1:0]      fill_cnt;

   logic sclk_s;
   logic copi_s;
   logic ncs_s;
   logic edge_en;
   logic sclk_rise;
   logic ncs_fall;
   logic ncs_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         copi_sync <= '0;
         ncs_sync  <= '1;
         sclk_hist <= 1'b0;
         copi_hist <= 1'b0;
         ncs_hist  <= 1'b1;
         fill_cnt  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the values that existed before this clock edge.
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_in};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_in};
         sclk_hist <= sclk_sync[SYNC_STAGES-1];
         copi_hist <= copi_sync[SYNC_STAGES-1];
         ncs_hist  <= ncs_sync[SYNC_STAGES-1];
         if (fill_cnt != FILL_DONE) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync[SYNC_STAGES-1];
   // COPI is sampled from its history flop: it lags the SCLK edge by one clk,
   // and the data was already stable at the pins for several clks by then.
   assign copi_s    = copi_hist;
   assign edge_en   = (fill_cnt == FILL_DONE);
   assign sclk_rise = edge_en &  sclk_s & ~sclk_hist;
   assign ncs_fall  = edge_en & ~ncs_s  &  ncs_hist;
   assign ncs_rise  = edge_en &  ncs_s  & ~ncs_hist;

   // ---------------------------------------------------------------------------
   // Next shift/count values. A final SCLK edge detected in the same cycle as
   // the nCS rise must be included before the frame is evaluated.
   // ---------------------------------------------------------------------------
   state_t      state;
   logic [15:0] shift_q;
   logic [4:0]  bit_cnt;
   logic        overflow;

   logic [15:0] shift_nxt;
   logic [4:0]  cnt_nxt;
   logic        ovf_nxt;
   logic        frame_ok;
   logic        frame_write;
   logic        pending;

   always_comb begin
      // NOTE: each always_comb output gets a default first, so no path
      // through the block can infer a latch.
      shift_nxt = shift_q;
      cnt_nxt   = bit_cnt;
      ovf_nxt   = overflow;
      if (sclk_rise) begin
         shift_nxt = {shift_q[14:0], copi_s};
         if (bit_cnt == 5'd16) begin
            ovf_nxt = 1'b1;
         end else begin
            cnt_nxt = bit_cnt + 5'd1;
         end
      end
   end

   assign frame_ok    = (cnt_nxt == 5'd16) && !ovf_nxt;
   assign frame_write = shift_nxt[15] && (shift_nxt[14:8] <= ADDR_LIM);
   // A write is still pending unless it is taken on this very edge.
   assign pending     = wr_valid && !wr_ready;

   // ---------------------------------------------------------------------------
   // Receive FSM and output stage
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift_q   <= '0;
         bit_cnt   <= '0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         frame_err <= 1'b0;
         if (wr_valid && wr_ready) begin
            wr_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (ncs_fall) begin
                  shift_q  <= '0;
                  bit_cnt  <= '0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end

            SHIFT: begin
               shift_q  <= shift_nxt;
               bit_cnt  <= cnt_nxt;
               overflow <= ovf_nxt;
               if (ncs_rise) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!frame_ok) begin
                     frame_err <= 1'b1;
                  end else if (frame_write) begin
                     if (pending) begin
                        // Overrun: keep the pending write, drop the new one.
                        frame_err <= 1'b1;
                     end else begin
                        // Also covers a handshake on this same edge: the
                        // reload overrides the clear above.
                        wr_valid <= 1'b1;
                        wr_addr  <= shift_nxt[14:8];
                        wr_data  <= shift_nxt[7:0];
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_rx
//
// Drives SPI frames at pin level, with directed cases and a randomized phase.
// A frame-level reference model predicts busy, frame_err, wr_valid, wr_addr and
// wr_data for every clk cycle. Each frame is reduced to an outcome (error, drop
// or write) using the frame rules. The outcome is scheduled SYNC_STAGES edges
// after the sampling edge of its nCS change. A handful of literal expectations
// pin the model to hand-computed results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_frame_rx;

   localparam int S        = 2;
   localparam int ADDR_MAX = 4;
   localparam int HALF     = 4;   // clk periods per SCLK phase

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       sclk_in  = 1'b0;
   logic       copi_in  = 1'b0;
   logic       ncs_in   = 1'b1;
   logic       wr_ready = 1'b1;
   logic       wr_valid;
   logic       busy;
   logic       frame_err;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;

   spi_frame_rx #(.SYNC_STAGES(S), .ADDR_MAX(ADDR_MAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk_in   (sclk_in),
      .copi_in   (copi_in),
      .ncs_in    (ncs_in),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;   // number of posedges seen so far
   int last_rise = 0;  // sampling edge of the most recent nCS rise

   typedef enum int {OUT_ERR, OUT_DROP, OUT_WR} outcome_t;
   typedef enum int {EV_BUSY, EV_END} ev_kind_t;
   typedef struct {
      int         at;
      ev_kind_t   kind;
      outcome_t   res;
      logic [6:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t        evq[$];
   logic       m_valid = 1'b0;
   logic       m_busy  = 1'b0;
   logic       m_err   = 1'b0;
   logic [6:0] m_addr  = '0;
   logic [7:0] m_data  = '0;

   bit   rand_ready  = 1'b0;
   logic ready_force = 1'b1;

   logic [14:0] hs_log[$];
   int          err_cnt      = 0;
   int          valid_cycles = 0;
   int          vrise_q[$];
   logic        prev_v = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Frame rules: wrong bit count is an error; reads and out-of-range
   // addresses are dropped; everything else is a write candidate.
   function automatic ev_t frame_event(input int at, input logic [31:0] bits, input int nbits);
      ev_t        e;
      logic [15:0] w;
      w      = bits[15:0];
      e.at   = at;
      e.kind = EV_END;
      e.addr = '0;
      e.data = '0;
      if (nbits != 16) begin
         e.res = OUT_ERR;
      end else if (!w[15] || int'(w[14:8]) > ADDR_MAX) begin
         e.res = OUT_DROP;
      end else begin
         e.res  = OUT_WR;
         e.addr = w[14:8];
         e.data = w[7:0];
      end
      return e;
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model, advanced once per posedge
   // ---------------------------------------------------------------------------
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            evq.delete();
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_err   = 1'b0;
            m_addr  = '0;
            m_data  = '0;
         end else begin
            bit pend;
            pend  = m_valid && !wr_ready;
            m_err = 1'b0;
            if (m_valid && wr_ready) m_valid = 1'b0;
            for (int i = 0; i < evq.size(); ) begin
               if (evq[i].at == cyc) begin
                  if (evq[i].kind == EV_BUSY) begin
                     m_busy = 1'b1;
                  end else begin
                     m_busy = 1'b0;
                     if (evq[i].res == OUT_ERR) begin
                        m_err = 1'b1;
                     end else if (evq[i].res == OUT_WR) begin
                        if (pend) begin
                           m_err = 1'b1;
                        end else begin
                           m_valid = 1'b1;
                           m_addr  = evq[i].addr;
                           m_data  = evq[i].data;
                        end
                     end
                  end
                  evq.delete(i);
               end else begin
                  i++;
               end
            end
         end
      end
   end

   // wr_ready source: test-controlled level or random per cycle.
   initial begin
      forever begin
         @(negedge clk);
         wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-cycle compare against the model, plus event logs
   // ---------------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("frame_err", 32'(frame_err), 32'(m_err));
            check("wr_valid", 32'(wr_valid), 32'(m_valid));
            if (m_valid) begin
               check("wr_addr", 32'(wr_addr), 32'(m_addr));
               check("wr_data", 32'(wr_data), 32'(m_data));
            end
            if (wr_valid && wr_ready) hs_log.push_back({wr_addr, wr_data});
            if (frame_err) err_cnt++;
            if (wr_valid) valid_cycles++;
            if (wr_valid && !prev_v) vrise_q.push_back(cyc);
         end
         prev_v = rst ? 1'b0 : wr_valid;
      end
   end

   // ---------------------------------------------------------------------------
   // Pin-level driver
   // ---------------------------------------------------------------------------
   task automatic mid_frame_reset();
      rst = 1'b1;
      #1;
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      tick(3);
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] bits, input int nbits, input int gap,
                             input int abort_after);
      ev_t b;
      bit  aborted;
      aborted = 1'b0;
      ncs_in  = 1'b0;
      b.at    = cyc + 1 + S;
      b.kind  = EV_BUSY;
      b.res   = OUT_DROP;
      b.addr  = '0;
      b.data  = '0;
      evq.push_back(b);
      for (int i = 0; i < nbits; i++) begin
         if (i == abort_after) begin
            mid_frame_reset();
            aborted = 1'b1;
         end
         copi_in = bits[nbits-1-i];
         tick(HALF);
         sclk_in = 1'b1;
         tick(HALF);
         sclk_in = 1'b0;
      end
      tick(HALF);
      ncs_in    = 1'b1;
      last_rise = cyc + 1;
      if (!aborted) evq.push_back(frame_event(cyc + 1 + S, bits, nbits));
      tick(gap);
   endtask

   task automatic expect_hs(input string name, input int idx, input logic [6:0] a,
                            input logic [7:0] d);
      if (hs_log.size() > idx) check(name, 32'(hs_log[idx]), 32'({a, d}));
      else                     check(name, 32'hFFFF_FFFF, 32'({a, d}));
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      int base_hs;
      int base_err;
      int base_vc;
      int lat;

      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(10);
      #1;
      check("reset_wr_valid", 32'(wr_valid), 32'd0);
      check("reset_wr_addr", 32'(wr_addr), 32'd0);
      check("reset_wr_data", 32'(wr_data), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      tick(1);

      // Single write, consumer always ready.
      ready_force = 1'b1;
      tick(2);
      base_hs  = hs_log.size();
      base_err = err_cnt;
      base_vc  = valid_cycles;
      send_frame(32'h8455, 16, 20, -1);
      check("t1_hs_count", 32'(hs_log.size() - base_hs), 32'd1);
      expect_hs("t1_hs_data", base_hs, 7'd4, 8'h55);
      check("t1_valid_cycles", 32'(valid_cycles - base_vc), 32'd1);
      lat = (vrise_q.size() > 0) ? vrise_q[vrise_q.size()-1] - last_rise : -1;
      check("t1_latency", 32'(lat), 32'(S));
      check("t1_no_err", 32'(err_cnt - base_err), 32'd0);

      // Read frame and out-of-range write: silently dropped.
      base_hs  = hs_log.size();
      base_err = err_cnt;
      send_frame(32'h0012, 16, 10, -1);
      send_frame(32'h85AA, 16, 10, -1);
      check("t2_no_hs", 32'(hs_log.size() - base_hs), 32'd0);
      check("t2_no_err", 32'(err_cnt - base_err), 32'd0);

      // Short and long frames flag errors; a valid frame afterwards still lands.
      base_hs  = hs_log.size();
      base_err = err_cnt;
      send_frame(32'h0000_4455, 15, 10, -1);
      send_frame(32'h0001_0455, 17, 10, -1);
      check("t3_err_count", 32'(err_cnt - base_err), 32'd2);
      check("t3_no_hs", 32'(hs_log.size() - base_hs), 32'd0);
      send_frame(32'h8001, 16, 10, -1);
      expect_hs("t3_hs_data", base_hs, 7'd0, 8'h01);

      // Overrun while the consumer stalls.
      ready_force = 1'b0;
      tick(2);
      base_hs  = hs_log.size();
      base_err = err_cnt;
      send_frame(32'h8102, 16, 10, -1);
      send_frame(32'h8203, 16, 10, -1);
      #1;
      check("t4_valid_held", 32'(wr_valid), 32'd1);
      check("t4_addr_held", 32'(wr_addr), 32'd1);
      check("t4_data_held", 32'(wr_data), 32'h02);
      check("t4_overrun_err", 32'(err_cnt - base_err), 32'd1);
      tick(1);
      ready_force = 1'b1;
      tick(5);
      #1;
      check("t4_valid_drop", 32'(wr_valid), 32'd0);
      check("t4_hs_count", 32'(hs_log.size() - base_hs), 32'd1);
      expect_hs("t4_hs_data", base_hs, 7'd1, 8'h02);
      tick(1);

      // Reset after 8 bits; the remainder of that frame must be ignored.
      base_hs  = hs_log.size();
      base_err = err_cnt;
      send_frame(32'h83FF, 16, 20, 8);
      check("t5_no_hs", 32'(hs_log.size() - base_hs), 32'd0);
      check("t5_no_err", 32'(err_cnt - base_err), 32'd0);
      send_frame(32'h83FF, 16, 20, -1);
      expect_hs("t5_hs_data", base_hs, 7'd3, 8'hFF);

      // Back-to-back frames with the minimum nCS gap.
      base_hs  = hs_log.size();
      base_err = err_cnt;
      send_frame(32'h8011, 16, S + 1, -1);
      send_frame(32'h8122, 16, 20, -1);
      check("t6_hs_count", 32'(hs_log.size() - base_hs), 32'd2);
      expect_hs("t6_hs_first", base_hs, 7'd0, 8'h11);
      expect_hs("t6_hs_second", base_hs + 1, 7'd1, 8'h22);
      check("t6_no_err", 32'(err_cnt - base_err), 32'd0);

      // Randomized frames with a randomly stalling consumer.
      rand_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         int          sel;
         int          nb;
         logic [31:0] w;
         sel = int'($urandom_range(0, 5));
         nb  = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
         w   = $urandom;
         if (nb == 16) begin
            w[15]   = ($urandom_range(0, 3) != 0);
            w[14:8] = 7'($urandom_range(0, 6));
         end
         send_frame(w, nb, int'($urandom_range(S + 1, 10)), -1);
      end
      rand_ready  = 1'b0;
      ready_force = 1'b1;
      tick(20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
